// File: rtl/rank_select.sv
// rtl/rank_select.sv - masked rank-order filter output selector
//
// Keeps a shadow copy of the N-sample window, shifting in lockstep with the
// upstream masked_ranks registers. Each cycle it picks the window sample
// whose masked rank equals the programmable target rank, and registers that
// sample as the filter output.
//
// Optional feature: define RANK_SELECT_CHECK_EN to enable selection
// checking. The checks are: target out of range, or not exactly one
// matching position. An error suppresses out_valid, holds out_sample and
// out_pos, and raises out_err. Without the macro, out_err is tied low. In
// that build an empty match selects sample 0 at position 0.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   in_valid     in_sample is a real sample this cycle
//   in_sample    sample entering the window (and the upstream comparators)
//   flush        synchronous clear of window validity and out_valid
//   mask         participating window positions (same as upstream mask)
//   ranks        upstream ranks, field j = ranks[j*RB +: RB], 0 if unmasked
//   target       requested rank, 1 = smallest masked sample
//   target_load  latch target into the target register
//   out_valid    out_sample holds a fresh result this cycle
//   out_sample   selected sample
//   out_pos      window position of the selected sample
//   out_err      selection invalid (checking build only)

module rank_select #(
   parameter  int N  = 7,
   parameter  int W  = 8,
   localparam int RB = $clog2(N + 1),
   localparam int PB = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [W-1:0]   in_sample,
   input  logic           flush,
   input  logic [N-1:0]   mask,
   input  logic [RB*N-1:0] ranks,
   input  logic [RB-1:0]  target,
   input  logic           target_load,
   output logic           out_valid,
   output logic [W-1:0]   out_sample,
   output logic [PB-1:0]  out_pos,
   output logic           out_err
);

   // Position N-1 is the newest sample, position 0 the oldest.
   logic [W-1:0]  win [N];
   logic [N-1:0]  vld;
   logic [RB-1:0] tgt;

   logic [N-1:0]  hit;
   logic          any_hit;
   logic [PB-1:0] sel_pos;
   logic [W-1:0]  sel_sample;
   logic          win_full;
   logic          err_c;
   logic          nxt_valid;

   // Window and validity shift every cycle with no enable, so that they
   // stay aligned with the upstream rank registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int j = 0; j < N; j++) begin
            win[j] <= '0;
         end
         vld <= '0;
         tgt <= RB'((N + 1) / 2);
      end else begin
         for (int j = 0; j < N - 1; j++) begin
            win[j] <= win[j+1];
         end
         win[N-1] <= in_sample;
         vld      <= flush ? '0 : {in_valid, vld[N-1:1]};
         if (target_load) begin
            tgt <= target;
         end
      end
   end

   assign win_full = &vld;

   always_comb begin
      hit = '0;
      for (int j = 0; j < N; j++) begin
         hit[j] = mask[j] && (ranks[j*RB +: RB] == tgt);
      end
   end

   // Priority encoder: scanning from the top down lets the lowest matching
   // index overwrite any higher one.
   always_comb begin
      any_hit    = 1'b0;
      sel_pos    = '0;
      sel_sample = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (hit[j]) begin
            any_hit    = 1'b1;
            sel_pos    = PB'(j);
            sel_sample = win[j];
         end
      end
   end

`ifdef RANK_SELECT_CHECK_EN
   logic [RB-1:0] mask_cnt;
   logic [RB-1:0] hit_cnt;

   always_comb begin
      mask_cnt = '0;
      hit_cnt  = '0;
      for (int j = 0; j < N; j++) begin
         mask_cnt = mask_cnt + RB'(mask[j]);
         hit_cnt  = hit_cnt + RB'(hit[j]);
      end
   end

   assign err_c = (tgt == '0) || (tgt > mask_cnt) || (hit_cnt != RB'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_err <= 1'b0;
      end else begin
         out_err <= win_full && err_c;
      end
   end
`else
   // Unchecked build: an empty match falls through to sample 0 at position 0
   // (sel_sample / sel_pos defaults), and any_hit is informational only.
   assign err_c   = 1'b0;
   assign out_err = 1'b0;
`endif

   assign nxt_valid = win_full && !flush && !err_c;

   // Result fields only move when a fresh result is produced, so a
   // consumer sees the last good selection while out_valid is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_sample <= '0;
         out_pos    <= '0;
      end else begin
         out_valid <= nxt_valid;
         if (nxt_valid) begin
            out_sample <= any_hit ? sel_sample : '0;
            out_pos    <= sel_pos;
         end
      end
   end

endmodule

// File: tb/tb_rank_select.sv
// tb/tb_rank_select.sv - directed self-checking bench for rank_select

module tb_rank_select;

   localparam int N  = 7;
   localparam int W  = 8;
   localparam int RB = 3;
   localparam int PB = 3;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic [W-1:0]    in_sample;
   logic            flush;
   logic [N-1:0]    mask;
   logic [RB*N-1:0] ranks;
   logic [RB-1:0]   target;
   logic            target_load;
   logic            out_valid;
   logic [W-1:0]    out_sample;
   logic [PB-1:0]   out_pos;
   logic            out_err;

   int total;
   int bad;
   int cy;

   logic [W-1:0] pat [N];
   logic [W-1:0] tw  [N];

   rank_select #(.N(N), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sample   (in_sample),
      .flush       (flush),
      .mask        (mask),
      .ranks       (ranks),
      .target      (target),
      .target_load (target_load),
      .out_valid   (out_valid),
      .out_sample  (out_sample),
      .out_pos     (out_pos),
      .out_err     (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the upstream masked_ranks: rank registers shift with the
   // sample, ranks are computed over the masked subset (ties by index).
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int j = 0; j < N; j++) tw[j] <= '0;
      end else begin
         for (int j = 0; j < N - 1; j++) tw[j] <= tw[j+1];
         tw[N-1] <= in_sample;
      end
   end

   always_comb begin
      int r;
      r = 0;
      ranks = '0;
      for (int j = 0; j < N; j++) begin
         if (mask[j]) begin
            r = 1;
            for (int k = 0; k < N; k++) begin
               if (mask[k] && ((tw[k] < tw[j]) || ((tw[k] == tw[j]) && (k < j))))
                  r = r + 1;
            end
            ranks[j*RB +: RB] = RB'(r);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cy);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cy = cy + 1;
   endtask

   task automatic drive();
      in_valid    = 1'b1;
      in_sample   = pat[cy % N];
      flush       = 1'b0;
      target_load = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cy    = 0;
      pat[0] = 8'd10; pat[1] = 8'd50; pat[2] = 8'd30; pat[3] = 8'd70;
      pat[4] = 8'd20; pat[5] = 8'd60; pat[6] = 8'd40;

      rst = 1'b0; in_valid = 1'b0; in_sample = '0; flush = 1'b0;
      mask = 7'h7F; target = '0; target_load = 1'b0;

      @(posedge clk); @(posedge clk); #1;
      chk("rst_valid",  out_valid,  0);
      chk("rst_sample", out_sample, 0);
      chk("rst_pos",    out_pos,    0);
      chk("rst_err",    out_err,    0);

      rst = 1'b1;
      cy  = 0;
      drive();
      for (int c = 1; c <= 50; c++) begin
         tick();
         drive();
         case (cy)
            1:  chk("s1_early_valid", out_valid, 0);
            7:  chk("s1_pre_valid", out_valid, 0);
            8: begin
               chk("s1_valid",  out_valid,  1);
               chk("s1_sample", out_sample, 40);
               chk("s1_pos",    out_pos,    6);
            end
            14: begin target = 3'd1; target_load = 1'b1; end
            15: begin
               chk("s2_old_tgt_sample", out_sample, 40);
               chk("s2_old_tgt_pos",    out_pos,    6);
            end
            16: begin
               chk("s2_min_sample", out_sample, 10);
               chk("s2_min_pos",    out_pos,    6);
               target = 3'd7; target_load = 1'b1;
            end
            17: begin
               chk("s2_min2_sample", out_sample, 10);
               chk("s2_min2_pos",    out_pos,    5);
            end
            18: begin
               chk("s2_max_sample", out_sample, 70);
               chk("s2_max_pos",    out_pos,    0);
            end
            20: begin target = 3'd2; target_load = 1'b1; end
            21: mask = 7'b0001111;
            22: begin
               chk("s3_valid",  out_valid,  1);
               chk("s3_sample", out_sample, 30);
               chk("s3_pos",    out_pos,    2);
               target = 3'd5; target_load = 1'b1;
            end
            23: begin
               chk("s3b_sample", out_sample, 30);
               chk("s3b_pos",    out_pos,    1);
            end
            24: begin
`ifdef RANK_SELECT_CHECK_EN
               chk("s4_valid",  out_valid,  0);
               chk("s4_err",    out_err,    1);
               chk("s4_sample", out_sample, 30);
               chk("s4_pos",    out_pos,    1);
`else
               chk("s4_valid",  out_valid,  1);
               chk("s4_err",    out_err,    0);
               chk("s4_sample", out_sample, 0);
               chk("s4_pos",    out_pos,    0);
`endif
               mask = 7'h7F;
               target = 3'd4; target_load = 1'b1;
            end
            25: begin
               chk("s4_rec_valid",  out_valid,  1);
               chk("s4_rec_err",    out_err,    0);
               chk("s4_rec_sample", out_sample, 50);
               chk("s4_rec_pos",    out_pos,    5);
            end
            26: begin
               chk("s4_med_sample", out_sample, 40);
               chk("s4_med_pos",    out_pos,    2);
            end
            28: in_valid = 1'b0;
            40: begin
               chk("s5_flush_pre", out_valid, 1);
               flush = 1'b1;
               target = 3'd1; target_load = 1'b1;
            end
            49: begin
               chk("s5_flush_post", out_valid, 1);
               chk("s5_flush_load_sample", out_sample, 10);
               chk("s5_flush_load_pos",    out_pos,    1);
            end
            default: ;
         endcase
         if (cy >= 29 && cy <= 37)
            chk("s5_bubble_valid", out_valid, (cy >= 30 && cy <= 36) ? 0 : 1);
         if (cy >= 41 && cy <= 48)
            chk("s5_flush_valid", out_valid, 0);
      end

      // Reset mid-stream with tgt = 1 loaded.
      #2;
      rst = 1'b0;
      #1;
      chk("s6_rst_valid",  out_valid,  0);
      chk("s6_rst_sample", out_sample, 0);
      chk("s6_rst_pos",    out_pos,    0);
      chk("s6_rst_err",    out_err,    0);
      tick();
      tick();
      rst = 1'b1;
      cy  = 0;
      drive();
      for (int c = 1; c <= 9; c++) begin
         tick();
         drive();
         if (cy == 7) chk("s6_pre_valid", out_valid, 0);
         if (cy == 8) begin
            chk("s6_valid",  out_valid,  1);
            chk("s6_sample", out_sample, 40);
            chk("s6_pos",    out_pos,    6);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
